// File: rtl/whack_game_fsm.sv
// -----------------------------------------------------------------------------
// whack_game_fsm
//   Game-control FSM for the whack-a-mole game. It sequences the start screen,
//   the pause between moles, the four mole windows and the game-over screen,
//   and it keeps the score and miss count for the HEX display path.
//
// Ports
//   iClock        in   1  system clock, rising edge
//   iReset        in   1  asynchronous, active-high reset
//   iStart        in   1  start/restart button level (debounced, active-high)
//   iKey          in   4  whack buttons, one per mole (levels, active-high)
//   oState        out  3  000 START, 001 GAME, 010..101 MOLE1..4, 110 GAMEOVER
//   oStateChange  out  1  one-cycle pulse in the first cycle of a new oState
//   oScore        out  8  hits this game, saturating at 255
//   oMisses       out  4  misses this game
// -----------------------------------------------------------------------------
module whack_game_fsm #(
  parameter int unsigned PAUSE_TICKS = 25_000_000,
  parameter int unsigned MOLE_TICKS  = 50_000_000,
  parameter int unsigned MAX_MISSES  = 3,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
  input  logic       iClock,
  input  logic       iReset,
  input  logic       iStart,
  input  logic [3:0] iKey,
  output logic [2:0] oState,
  output logic       oStateChange,
  output logic [7:0] oScore,
  output logic [3:0] oMisses
);

  // Screen codes double as the state encoding so oState is a plain register.
  localparam logic [2:0] ST_START    = 3'b000;
  localparam logic [2:0] ST_GAME     = 3'b001;
  localparam logic [2:0] ST_MOLE1    = 3'b010;
  localparam logic [2:0] ST_MOLE2    = 3'b011;
  localparam logic [2:0] ST_MOLE3    = 3'b100;
  localparam logic [2:0] ST_MOLE4    = 3'b101;
  localparam logic [2:0] ST_GAMEOVER = 3'b110;

  localparam logic [31:0] PAUSE_LAST = 32'(PAUSE_TICKS - 1);
  localparam logic [31:0] MOLE_LAST  = 32'(MOLE_TICKS - 1);
  localparam logic [3:0]  MISS_LIMIT = 4'(MAX_MISSES);

  logic [2:0]  state_q, state_d;
  logic        change_q, change_d;
  logic [7:0]  score_q, score_d;
  logic [3:0]  misses_q, misses_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  lfsr_q, lfsr_d;
  logic        start_prev_q;
  logic [3:0]  key_prev_q;

  logic        start_rise;
  logic [3:0]  key_rise;
  logic        in_mole;
  logic [1:0]  target_idx;
  logic [3:0]  target_mask;
  logic        other_rise;
  logic        hit;
  logic        miss;
  logic [3:0]  misses_inc;

  // Rising edges only; the previous-sample registers reset high so a button
  // held through reset is not seen as a press when reset releases.
  assign start_rise = iStart & ~start_prev_q;
  assign key_rise   = iKey & ~key_prev_q;

  // Fibonacci LFSR, taps 8,6,5,4 (bits 7,5,4,3), free-running in all states.
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

  assign in_mole     = (state_q >= ST_MOLE1) && (state_q <= ST_MOLE4);
  assign target_idx  = 2'(state_q - ST_MOLE1);
  assign target_mask = 4'b0001 << target_idx;

  // A wrong key beats a simultaneous correct key; a hit in the timeout cycle
  // still counts as a hit.
  assign other_rise = |(key_rise & ~target_mask);
  assign hit        = !other_rise && |(key_rise & target_mask);
  assign miss       = other_rise || (!hit && (cnt_q == MOLE_LAST));
  assign misses_inc = misses_q + 4'd1;

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    score_d  = score_q;
    misses_d = misses_q;

    case (state_q)
      ST_START: begin
        if (start_rise) begin
          state_d  = ST_GAME;
          score_d  = 8'd0;
          misses_d = 4'd0;
        end
      end

      ST_GAME: begin
        if (cnt_q == PAUSE_LAST) begin
          state_d = ST_MOLE1 + {1'b0, lfsr_q[1:0]};
        end
      end

      ST_MOLE1, ST_MOLE2, ST_MOLE3, ST_MOLE4: begin
        if (hit) begin
          score_d = (score_q == 8'hFF) ? score_q : score_q + 8'd1;
          state_d = ST_GAME;
        end else if (miss) begin
          misses_d = misses_inc;
          state_d  = (misses_inc == MISS_LIMIT) ? ST_GAMEOVER : ST_GAME;
        end
      end

      ST_GAMEOVER: begin
        if (start_rise) begin
          state_d = ST_START;
        end
      end

      default: state_d = ST_START;  // 111 recovers to the start screen
    endcase
  end

  always_comb begin
    change_d = (state_d != state_q);
    if (change_d) begin
      cnt_d = 32'd0;
    end else if ((state_q == ST_GAME) || in_mole) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q      <= ST_START;
      change_q     <= 1'b0;
      score_q      <= 8'd0;
      misses_q     <= 4'd0;
      cnt_q        <= 32'd0;
      lfsr_q       <= LFSR_SEED;
      start_prev_q <= 1'b1;
      key_prev_q   <= 4'hF;
    end else begin
      state_q      <= state_d;
      change_q     <= change_d;
      score_q      <= score_d;
      misses_q     <= misses_d;
      cnt_q        <= cnt_d;
      lfsr_q       <= lfsr_d;
      start_prev_q <= iStart;
      key_prev_q   <= iKey;
    end
  end

  assign oState       = state_q;
  assign oStateChange = change_q;
  assign oScore       = score_q;
  assign oMisses      = misses_q;

endmodule

// File: tb/tb_whack_game_fsm.sv
// -----------------------------------------------------------------------------
// tb_whack_game_fsm
//   Self-checking bench for whack_game_fsm with short timing parameters.
//   A behavioural game model (mode, dwell count, target, score, misses) is
//   advanced on every rising edge from the same inputs and all four outputs
//   are compared one time unit after each edge.
// -----------------------------------------------------------------------------
module tb_whack_game_fsm;

  localparam int P_TICKS  = 4;
  localparam int M_TICKS  = 8;
  localparam int MAXMISS  = 3;
  localparam logic [7:0] SEED = 8'hA5;

  logic       iClock = 1'b0;
  logic       iReset;
  logic       iStart;
  logic [3:0] iKey;
  logic [2:0] oState;
  logic       oStateChange;
  logic [7:0] oScore;
  logic [3:0] oMisses;

  always #5 iClock = ~iClock;

  whack_game_fsm #(
    .PAUSE_TICKS(P_TICKS),
    .MOLE_TICKS (M_TICKS),
    .MAX_MISSES (MAXMISS),
    .LFSR_SEED  (SEED)
  ) dut (
    .iClock      (iClock),
    .iReset      (iReset),
    .iStart      (iStart),
    .iKey        (iKey),
    .oState      (oState),
    .oStateChange(oStateChange),
    .oScore      (oScore),
    .oMisses     (oMisses)
  );

  // ---------------------------------------------------------------- model
  typedef enum int {M_IDLE, M_PAUSE, M_MOLE, M_OVER} mode_t;

  mode_t m_mode;
  int    m_target;
  int    m_dwell;    // edges spent in the current mode
  int    m_score;
  int    m_misses;
  int    m_lfsr;
  int    m_prev_s;
  int    m_prev_k;
  int    m_change;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int exp_state();
    case (m_mode)
      M_IDLE:  return 0;
      M_PAUSE: return 1;
      M_MOLE:  return 2 + m_target;
      default: return 6;
    endcase
  endfunction

  task automatic model_reset();
    m_mode   = M_IDLE;
    m_target = 0;
    m_dwell  = 0;
    m_score  = 0;
    m_misses = 0;
    m_lfsr   = SEED;
    m_prev_s = 1;
    m_prev_k = 15;
    m_change = 0;
  endtask

  task automatic model_edge();
    int rs, rk, chg;
    if (iReset) begin
      model_reset();
      return;
    end
    rs = (iStart && m_prev_s == 0) ? 1 : 0;
    rk = int'(iKey) & ~m_prev_k & 15;
    m_prev_s = int'(iStart);
    m_prev_k = int'(iKey);
    chg = 0;
    case (m_mode)
      M_IDLE: if (rs != 0) begin
        m_mode = M_PAUSE; m_score = 0; m_misses = 0; chg = 1;
      end
      M_PAUSE: begin
        m_dwell++;
        if (m_dwell == P_TICKS) begin
          m_mode = M_MOLE; m_target = m_lfsr % 4; chg = 1;
        end
      end
      M_MOLE: begin
        m_dwell++;
        if ((rk & ~(1 << m_target) & 15) != 0 ||
            (((rk >> m_target) & 1) == 0 && m_dwell == M_TICKS)) begin
          m_misses++;
          m_mode = (m_misses == MAXMISS) ? M_OVER : M_PAUSE;
          chg = 1;
        end else if (((rk >> m_target) & 1) != 0) begin
          if (m_score < 255) m_score++;
          m_mode = M_PAUSE;
          chg = 1;
        end
      end
      default: if (rs != 0) begin
        m_mode = M_IDLE; chg = 1;
      end
    endcase
    if (chg != 0) m_dwell = 0;
    m_change = chg;
    m_lfsr = ((m_lfsr << 1) |
              (((m_lfsr >> 7) ^ (m_lfsr >> 5) ^ (m_lfsr >> 4) ^ (m_lfsr >> 3)) & 1)) & 255;
  endtask

  task automatic compare_all();
    check("state",  int'(oState),       exp_state());
    check("change", int'(oStateChange), m_change);
    check("score",  int'(oScore),       m_score);
    check("misses", int'(oMisses),      m_misses);
  endtask

  // One clock: apply inputs, advance model at the edge, compare after it.
  task automatic cyc(input int s, input int k);
    iStart = s[0];
    iKey   = k[3:0];
    @(posedge iClock);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic wait_mode(input mode_t want, input int budget);
    int n;
    n = 0;
    while (m_mode != want && n < budget) begin
      cyc(0, 0);
      n++;
    end
    check("reach_mode", int'(m_mode), int'(want));
  endtask

  // Run out the GAME pause. With noise, random keys/start are driven (they
  // must be ignored); with hold, the upcoming target key is raised in the
  // last GAME cycle and returned so the caller keeps it held.
  task automatic to_mole(input bit noise, input bit hold, output int held);
    int n, k, s;
    held = 0;
    n = 0;
    while (m_mode == M_PAUSE && n < 50) begin
      k = 0;
      s = 0;
      if (hold && m_dwell == P_TICKS - 1) begin
        k = 1 << (m_lfsr % 4);
        held = k;
      end else if (noise && m_dwell < P_TICKS - 1) begin
        k = int'($urandom_range(0, 15));
      end
      if (noise) s = int'($urandom_range(0, 1));
      cyc(s, k);
      n++;
    end
    check("enter_mole", int'(m_mode), int'(M_MOLE));
  endtask

  // action: 0 hit after random delay, 1 target+other together,
  //         2 wrong key after random delay, 3 no key (timeout)
  task automatic play_mole(input int action);
    int t, other, d, n;
    t     = m_target;
    other = (t + int'($urandom_range(1, 3))) % 4;
    d     = int'($urandom_range(0, M_TICKS - 1));
    case (action)
      0: begin
        repeat (d) cyc(0, 0);
        cyc(0, 1 << t);
      end
      1: cyc(0, (1 << t) | (1 << other));
      2: begin
        repeat (d) cyc(0, 0);
        cyc(0, 1 << other);
      end
      default: begin
        n = 0;
        while (m_mode == M_MOLE && n < M_TICKS + 2) begin
          cyc(0, 0);
          n++;
        end
      end
    endcase
    check("left_mole", (m_mode != M_MOLE) ? 1 : 0, 1);
    cyc(0, 0);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int held, n, a, score_before;

    iReset = 1'b1;
    iStart = 1'b0;
    iKey   = 4'h0;
    model_reset();
    #12;
    check("rst_state",  int'(oState),       0);
    check("rst_change", int'(oStateChange), 0);
    check("rst_score",  int'(oScore),       0);
    check("rst_misses", int'(oMisses),      0);
    iReset = 1'b0;
    cyc(0, 0);
    cyc(0, 0);

    // Start, one hit, one wrong-key miss, then reset in the middle of a mole.
    cyc(1, 0);
    cyc(0, 0);
    to_mole(0, 0, held);
    play_mole(0);
    to_mole(0, 0, held);
    play_mole(2);
    to_mole(0, 0, held);
    #2;
    iReset = 1'b1;
    #1;
    model_reset();
    check("async_state",  int'(oState),       0);
    check("async_change", int'(oStateChange), 0);
    check("async_score",  int'(oScore),       0);
    check("async_misses", int'(oMisses),      0);
    cyc(0, 0);
    iStart = 1'b1;
    iKey   = 4'hF;
    cyc(1, 15);
    iReset = 1'b0;
    repeat (4) cyc(1, 15);
    check("held_through_reset", int'(oState), 0);
    cyc(0, 0);

    // Start pulse, then a combined target+other press (miss, score held).
    cyc(1, 0);
    check("start_pulse", int'(oStateChange), 1);
    cyc(0, 0);
    check("pulse_one_cycle", int'(oStateChange), 0);
    to_mole(1, 0, held);
    score_before = m_score;
    play_mole(1);
    check("combo_score", int'(oScore), score_before);
    check("combo_miss",  int'(oMisses), 1);

    // Randomised windows with input noise during the pause.
    for (int w = 0; w < 24; w++) begin
      to_mole(1, 0, held);
      a = int'($urandom_range(0, 3));
      if (a != 0 && m_misses >= MAXMISS - 1) a = 0;
      play_mole(a);
    end

    // Time out until game over; score must be held there.
    n = 0;
    while (m_mode != M_OVER && n < 5) begin
      to_mole(0, 0, held);
      play_mole(3);
      n++;
    end
    check("gameover", int'(oState), 6);
    score_before = m_score;
    repeat (3) cyc(0, 0);
    check("over_score_held", int'(oScore), score_before);
    cyc(1, 0);
    cyc(0, 0);
    check("over_to_start", int'(oState), 0);
    cyc(1, 0);
    check("restart_score", int'(oScore), 0);
    cyc(0, 0);

    // Three silent mole windows: each lasts exactly MOLE_TICKS cycles.
    for (int i = 0; i < 3; i++) begin
      to_mole(0, 0, held);
      n = 0;
      while (m_mode == M_MOLE && n < M_TICKS + 4) begin
        cyc(0, 0);
        n++;
      end
      check("mole_len", n, M_TICKS);
      check("miss_count", int'(oMisses), i + 1);
    end
    check("three_miss_over", int'(oState), 6);

    // Target key held from before mole entry: no hit, timeout miss.
    cyc(1, 0);
    cyc(0, 0);
    wait_mode(M_IDLE, 4);
    cyc(1, 0);
    cyc(0, 0);
    to_mole(0, 1, held);
    n = 0;
    while (m_mode == M_MOLE && n < M_TICKS + 4) begin
      cyc(0, held);
      n++;
    end
    check("held_len", n, M_TICKS);
    check("held_miss", int'(oMisses), 1);
    check("held_no_hit", int'(oScore), 0);
    cyc(0, 0);

    // Score saturation: 256 immediate hits.
    for (int i = 0; i < 256; i++) begin
      to_mole(0, 0, held);
      cyc(0, 1 << m_target);
    end
    cyc(0, 0);
    check("score_sat", int'(oScore), 255);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
